// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Runtime-programmable serial bit-pattern detector. Compares the most recent
//   len valid bits against a programmable pattern and emits a registered
//   one-cycle pulse on a match. Reset defaults reproduce the legacy 1101
//   overlapping Moore detector.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   cfg_load     latch cfg_pattern/cfg_len/cfg_overlap on this edge
//   cfg_pattern  pattern, right-aligned; bit[len-1] is the first bit received
//   cfg_len      pattern length, legal range 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = each match needs len fresh bits
//   cfg_err      one-cycle pulse when a load is rejected (illegal length)
//   din_valid    qualifies din
//   din          serial data bit
//   count_clr    synchronous clear of match_count (wins over an increment)
//   detected     one-cycle match pulse, the cycle after the final pattern bit
//   match_count  saturating count of matches
module seq_detector_param #(
   parameter int unsigned        MAX_LEN     = 8,
   parameter int unsigned        CNT_W       = 16,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1101,
   parameter int unsigned        DEF_LEN     = 4,
   parameter bit                 DEF_OVERLAP = 1'b1,
   localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               cfg_err,
   input  logic               din_valid,
   input  logic               din,
   input  logic               count_clr,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count
);

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;

   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_inc;
   logic               match;
   logic               take;
   logic               hit;
   logic               cfg_ok;

   // mask selects the low len_q bits; pattern bits above len-1 never compare.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   // Match is judged on the incoming bit, so {hist, din} is the window that
   // will exist after this edge. The extra top bit is masked off.
   always_comb begin
      fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
      match    = ((({hist, din}) ^ {1'b0, pat_q}) & {1'b0, mask}) == '0
                 && (fill_inc >= {1'b0, len_q});
      take     = din_valid && !cfg_load;
      hit      = take && match;
      cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q       <= DEF_PATTERN;
         len_q       <= LEN_W'(DEF_LEN);
         overlap_q   <= DEF_OVERLAP;
         hist        <= '0;
         fill        <= '0;
         detected    <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         detected <= 1'b0;
         cfg_err  <= 1'b0;

         if (cfg_load) begin
            // A load edge never consumes din, accepted or not.
            if (cfg_ok) begin
               pat_q     <= cfg_pattern;
               len_q     <= cfg_len;
               overlap_q <= cfg_overlap;
               hist      <= '0;
               fill      <= '0;
            end else begin
               cfg_err <= 1'b1;
            end
         end else if (din_valid) begin
            hist     <= {hist[MAX_LEN-2:0], din};
            detected <= match;
            if (match && !overlap_q) begin
               fill <= '0;
            end else if (fill != LEN_W'(MAX_LEN)) begin
               fill <= fill + LEN_W'(1);
            end
         end

         if (count_clr) begin
            match_count <= '0;
         end else if (hit && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Directed bench for seq_detector_param. Two instances share all inputs:
//   one with the default 16-bit counter and one with a 2-bit counter so that
//   saturation is reachable. Expected outputs are queued as each step is
//   driven and popped once the edge has produced the registered outputs.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LEN_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cfg_err, cfg_err2;
   logic               din_valid;
   logic               din;
   logic               count_clr;
   logic               detected, detected2;
   logic [15:0]        match_count;
   logic [1:0]         match_count2;

   int checks = 0;
   int errors = 0;
   int m1 = 0;   // expected count, 16-bit instance
   int m2 = 0;   // expected count, 2-bit instance

   typedef struct {
      logic det;
      logic err;
      int   c1;
      int   c2;
   } exp_t;

   exp_t sb[$];

   seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
      .din_valid(din_valid), .din(din), .count_clr(count_clr),
      .detected(detected), .match_count(match_count)
   );

   seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
      .din_valid(din_valid), .din(din), .count_clr(count_clr),
      .detected(detected2), .match_count(match_count2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, "_det"},  {31'd0, detected},     {31'd0, e.det});
      chk({tag, "_det2"}, {31'd0, detected2},    {31'd0, e.det});
      chk({tag, "_err"},  {31'd0, cfg_err},      {31'd0, e.err});
      chk({tag, "_err2"}, {31'd0, cfg_err2},     {31'd0, e.err});
      chk({tag, "_cnt"},  {16'd0, match_count},  e.c1);
      chk({tag, "_cnt2"}, {30'd0, match_count2}, e.c2);
   endtask

   // One data cycle; edet is the hand-derived detect expectation for it.
   task automatic step(input logic v, input logic d, input logic clr,
                       input logic edet, input string tag);
      exp_t e;
      @(negedge clk);
      cfg_load  = 1'b0;
      din_valid = v;
      din       = d;
      count_clr = clr;
      if (clr) begin
         m1 = 0;
         m2 = 0;
      end else if (edet) begin
         if (m1 < 65535) m1++;
         if (m2 < 3)     m2++;
      end
      e.det = edet; e.err = 1'b0; e.c1 = m1; e.c2 = m2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(tag, e);
   endtask

   // Config load with din_valid=1, din=0 so an illegally consumed bit shows up.
   task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic ov, input logic eerr, input string tag);
      exp_t e;
      @(negedge clk);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      din_valid   = 1'b1;
      din         = 1'b0;
      count_clr   = 1'b0;
      e.det = 1'b0; e.err = eerr; e.c1 = m1; e.c2 = m2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(tag, e);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic rst(input string tag);
      exp_t e;
      @(negedge clk);
      din_valid = 1'b0;
      cfg_load  = 1'b0;
      count_clr = 1'b0;
      #2 reset = 1'b1;
      m1 = 0;
      m2 = 0;
      e.det = 1'b0; e.err = 1'b0; e.c1 = 0; e.c2 = 0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check_all(tag, e);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      cfg_load    = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      din_valid   = 1'b0;
      din         = 1'b0;
      count_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      begin
         exp_t e0;
         e0.det = 1'b0; e0.err = 1'b0; e0.c1 = 0; e0.c2 = 0;
         check_all("reset", e0);
      end
      @(negedge clk);
      reset = 1'b0;

      // 1: defaults, 1101 overlapping, stream 1101101 -> pulses after bits 4 and 7
      step(1, 1, 0, 0, "t1_b1");
      step(1, 1, 0, 0, "t1_b2");
      step(1, 0, 0, 0, "t1_b3");
      step(1, 1, 0, 1, "t1_b4");
      step(1, 1, 0, 0, "t1_b5");
      step(1, 0, 0, 0, "t1_b6");
      step(1, 1, 0, 1, "t1_b7");
      chk("t1_count", {16'd0, match_count}, 2);
      step(0, 1, 1, 0, "t1_clr");

      // 2: 1101 non-overlapping -> only the first match
      cfg(8'b0000_1101, 4'd4, 1'b0, 1'b0, "t2_cfg");
      step(1, 1, 0, 0, "t2_b1");
      step(1, 1, 0, 0, "t2_b2");
      step(1, 0, 0, 0, "t2_b3");
      step(1, 1, 0, 1, "t2_b4");
      step(1, 1, 0, 0, "t2_b5");
      step(1, 0, 0, 0, "t2_b6");
      step(1, 1, 0, 0, "t2_b7");
      chk("t2_count", {16'd0, match_count}, 1);

      // 3: 8-bit pattern with valid gaps; gaps carry din=1 which must be ignored
      cfg(8'b1010_1010, 4'd8, 1'b1, 1'b0, "t3_cfg");
      step(1, 1, 0, 0, "t3_b1");
      step(1, 0, 0, 0, "t3_b2");
      step(1, 1, 0, 0, "t3_b3");
      step(0, 1, 0, 0, "t3_g1");
      step(0, 1, 0, 0, "t3_g2");
      step(0, 1, 0, 0, "t3_g3");
      step(1, 0, 0, 0, "t3_b4");
      step(1, 1, 0, 0, "t3_b5");
      step(1, 0, 0, 0, "t3_b6");
      step(0, 1, 0, 0, "t3_g4");
      step(1, 1, 0, 0, "t3_b7");
      step(1, 0, 0, 1, "t3_b8");
      step(1, 1, 0, 0, "t3_b9");
      step(1, 0, 0, 1, "t3_b10");
      chk("t3_count", {16'd0, match_count}, 3);

      // 4: back to defaults; rejected loads mid-pattern keep history intact
      rst("t4_rst");
      step(1, 1, 0, 0, "t4_b1");
      step(1, 1, 0, 0, "t4_b2");
      cfg(8'b1111_1111, 4'd0, 1'b0, 1'b1, "t4_len0");
      cfg(8'b1111_1111, 4'd9, 1'b0, 1'b1, "t4_len9");
      step(1, 0, 0, 0, "t4_b3");
      step(1, 1, 0, 1, "t4_b4");
      // an accepted load clears history: 11 | load | 01 must not match
      step(1, 1, 0, 0, "t4_c1");
      step(1, 1, 0, 0, "t4_c2");
      cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, "t4_ok");
      step(1, 0, 0, 0, "t4_c3");
      step(1, 1, 0, 0, "t4_c4");
      step(1, 1, 0, 0, "t4_c5");
      step(1, 1, 0, 0, "t4_c6");
      step(1, 0, 0, 0, "t4_c7");
      step(1, 1, 0, 1, "t4_c8");
      // len 3 with junk above bit 2: only 110 is compared
      cfg(8'b1111_0110, 4'd3, 1'b1, 1'b0, "t4_len3");
      step(1, 1, 0, 0, "t4_d1");
      step(1, 1, 0, 0, "t4_d2");
      step(1, 0, 0, 1, "t4_d3");

      // 5: saturation of the 2-bit counter, then clear coinciding with a match
      rst("t5_rst");
      for (int r = 0; r < 4; r++) begin
         if (r == 0) step(1, 1, 0, 0, "t5_lead");
         step(1, 1, 0, 0, "t5_a");
         step(1, 0, 0, 0, "t5_b");
         step(1, 1, 0, 1, "t5_m");
      end
      chk("t5_sat2", {30'd0, match_count2}, 3);
      chk("t5_cnt",  {16'd0, match_count}, 4);
      step(1, 1, 0, 0, "t5_e1");
      step(1, 0, 0, 0, "t5_e2");
      step(1, 1, 1, 1, "t5_clrhit");

      // 6: reset discards partial history
      rst("t6_rst0");
      step(1, 1, 0, 0, "t6_p1");
      step(1, 1, 0, 0, "t6_p2");
      step(1, 0, 0, 0, "t6_p3");
      rst("t6_rst1");
      step(1, 1, 0, 0, "t6_q1");
      step(1, 1, 0, 0, "t6_q2");
      step(1, 1, 0, 0, "t6_q3");
      step(1, 0, 0, 0, "t6_q4");
      step(1, 1, 0, 1, "t6_q5");
      step(0, 0, 0, 0, "t6_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector, a parametrised successor to the team's fixed 1101 Moore detector.
- Pattern, length (1..MAX_LEN) and overlap mode are loaded through a config strobe. Input is qualified by din_valid.
- Produces a registered one-cycle detect pulse and a saturating match counter.
- Sits on serial framing/sync-word paths. Reset defaults reproduce the legacy 1101 overlapping detector.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 16: match_count width.
- DEF_PATTERN, 8'b0000_1101: reset pattern, right-aligned, MAX_LEN bits wide.
- DEF_LEN, 4: reset pattern length.
- DEF_OVERLAP, 1: reset overlap mode.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- cfg_load, input, 1: latch cfg_* on this edge.
- cfg_pattern, input, MAX_LEN: pattern, right-aligned; bit[len-1] is the first bit received.
- cfg_len, input, LEN_W=$clog2(MAX_LEN+1): pattern length.
- cfg_overlap, input, 1: 1 = overlapping matches allowed, 0 = non-overlapping.
- cfg_err, output, 1: one-cycle pulse when a load is rejected.
- din_valid, input, 1: din qualifier.
- din, input, 1: serial data bit.
- count_clr, input, 1: synchronous clear of match_count.
- detected, output, 1: one-cycle match pulse.
- match_count, output, CNT_W: saturating count of matches.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - detected=0, cfg_err=0, match_count=0.
  - History register=0, fill counter=0.
  - Config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
- Internal state:
  - hist[MAX_LEN-1:0] shift register; the new bit enters at bit 0.
  - fill[LEN_W-1:0] counts valid bits since the last clear, saturating at MAX_LEN.
- Sampling: a bit is consumed only on an edge with din_valid=1 and cfg_load=0. When din_valid=0, hist, fill and config hold and detected=0 next cycle. Gaps never break a partial match.
- Match condition, evaluated on the incoming bit: {hist, din} low len bits == pattern low len bits AND fill+1 >= len.
- Latency: detected is registered. It is high for exactly the one cycle following the edge that sampled the final pattern bit (same timing as the legacy Moore output). A match on consecutive valid bits gives consecutive pulses.
- Overlap=1: after a match, hist and fill update normally. Example: 1101101 with pattern 1101 matches twice.
- Overlap=0: on the match edge, fill is cleared to 0. The next match needs len fresh valid bits.
- Config load (cfg_load=1 at an edge):
  - If 1 <= cfg_len <= MAX_LEN: latch pattern, len and overlap; clear hist and fill; detected=0 next cycle; din is not sampled that edge; match_count is unaffected.
  - Otherwise: config, hist and fill are unchanged, din is not sampled, and cfg_err pulses for one cycle.
- Pattern bits above len-1 are ignored in the compare.
- match_count increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- count_clr sets match_count to 0. If it coincides with a match, clear wins and the result is 0; detected still pulses.
- Reset mid-operation forces all reset values immediately and asynchronously, discards partial history, and restores the default config.
- States: RUN only after reset; the config path is the only mode change. No idle or unconfigured state exists.

Test Plan:
1. Defaults, overlap=1: stream 1,1,0,1,1,0,1 with din_valid=1 -> detected high in the cycles after bit 4 and bit 7; match_count=2.
2. Load pattern 1101, len 4, overlap=0; same stream -> single pulse after bit 4, none after bit 7; match_count=1; cfg_err stays 0.
3. Load pattern 8'b1010_1010, len 8. Send 10101010 with din_valid deasserted for 3 cycles after bit 3 and 1 cycle after bit 6 -> exactly one pulse, after the 8th valid bit. Send a further 10 in overlap mode -> a second pulse.
4. cfg_load with cfg_len=0, then with cfg_len=9 -> cfg_err pulses each time; the default 1101 detection still works afterwards.
5. CNT_W=2, overlap=1: stream 1101101101101 (4 matches) -> match_count saturates at 3. Assert count_clr on the edge of a 5th match -> match_count=0, detected=1.
6. Feed 1,1,0, then pulse reset, then send 1 -> no detect, match_count=0. Then send 1101 -> detect after the 4th bit.
